// File: rtl/decode_regfile.sv
// ---------------------------------------------------------------------------
// decode_regfile
//   Decode stage with an integrated 15 x 64-bit register file. Decodes the
//   source and destination register specifiers from the fetched icode, reads
//   the operands, and registers everything for the next stage. Writeback runs
//   on every edge, independent of stall and in_valid. Capturing a halt
//   (icode 0) sets a sticky flag that blocks further captures until reset.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid             fetched instruction present this cycle
//   icode, ifun, rA, rB  fetched instruction fields (4'hF = no register)
//   cnd                  condition result; enables dstE for cmovXX
//   stall                freeze all registered outputs, ignore in_valid
//   wb_dstE/M, wb_valE/M writeback ports (4'hF = no write, M wins on a tie)
//   out_valid            outputs hold a decoded instruction
//   srcA/B, dstE/M       registered decoded specifiers
//   valA, valB           registered operand values
//   out_icode            registered icode
//   halted               sticky halt flag
//   bad_icode            captured icode was C-F
//
// Configuration
//   DECODE_WB_BYPASS_EN  when defined, operands read in the same cycle as a
//                        writeback to that register see the written value.
//                        Otherwise they see the pre-edge contents.
// ---------------------------------------------------------------------------
module decode_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic        stall,
    input  logic [3:0]  wb_dstE,
    input  logic [3:0]  wb_dstM,
    input  logic [63:0] wb_valE,
    input  logic [63:0] wb_valM,
    output logic        out_valid,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  out_icode,
    output logic        halted,
    output logic        bad_icode
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [63:0] regs_q [15];

    logic        out_valid_q, halted_q, bad_icode_q;
    logic [3:0]  src_a_q, src_b_q, dst_e_q, dst_m_q, icode_q;
    logic [63:0] val_a_q, val_b_q;

    logic [3:0]  src_a_d, src_b_d, dst_e_d, dst_m_d;
    logic [63:0] val_a_d, val_b_d;
    logic        capture;

    // ifun does not affect decode; it is carried only for interface symmetry.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    assign capture = in_valid && !stall && !halted_q;

    // Specifier decode; icodes outside 0-B fall through to "no register".
    always_comb begin
        src_a_d = RNONE;
        src_b_d = RNONE;
        dst_e_d = RNONE;
        dst_m_d = RNONE;
        case (icode)
            4'h2: begin
                src_a_d = rA;
                dst_e_d = cnd ? rB : RNONE;
            end
            4'h3: dst_e_d = rB;
            4'h4: begin
                src_a_d = rA;
                src_b_d = rB;
            end
            4'h5: begin
                src_b_d = rB;
                dst_m_d = rA;
            end
            4'h6: begin
                src_a_d = rA;
                src_b_d = rB;
                dst_e_d = rB;
            end
            4'h8: begin
                src_b_d = RSP;
                dst_e_d = RSP;
            end
            4'h9: begin
                src_a_d = RSP;
                src_b_d = RSP;
                dst_e_d = RSP;
            end
            4'hA: begin
                src_a_d = rA;
                src_b_d = RSP;
                dst_e_d = RSP;
            end
            4'hB: begin
                src_a_d = RSP;
                src_b_d = RSP;
                dst_e_d = RSP;
                dst_m_d = rA;
            end
            default: ;
        endcase
    end

    // Operand read; index F is the hardwired zero register.
    always_comb begin
        val_a_d = '0;
        val_b_d = '0;
        if (src_a_d != RNONE) val_a_d = regs_q[src_a_d];
        if (src_b_d != RNONE) val_b_d = regs_q[src_b_d];
`ifdef DECODE_WB_BYPASS_EN
        // Forward the same-edge writeback; M is checked first so it wins.
        if (src_a_d != RNONE) begin
            if (wb_dstM == src_a_d)      val_a_d = wb_valM;
            else if (wb_dstE == src_a_d) val_a_d = wb_valE;
        end
        if (src_b_d != RNONE) begin
            if (wb_dstM == src_b_d)      val_b_d = wb_valM;
            else if (wb_dstE == src_b_d) val_b_d = wb_valE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            bad_icode_q <= 1'b0;
            src_a_q     <= RNONE;
            src_b_q     <= RNONE;
            dst_e_q     <= RNONE;
            dst_m_q     <= RNONE;
            icode_q     <= 4'h1;
            val_a_q     <= '0;
            val_b_q     <= '0;
        end else begin
            // E first, then M, so M takes the register on a shared target.
            if (wb_dstE != RNONE) regs_q[wb_dstE] <= wb_valE;
            if (wb_dstM != RNONE) regs_q[wb_dstM] <= wb_valM;

            if (!stall) begin
                out_valid_q <= capture;
                if (capture) begin
                    src_a_q     <= src_a_d;
                    src_b_q     <= src_b_d;
                    dst_e_q     <= dst_e_d;
                    dst_m_q     <= dst_m_d;
                    val_a_q     <= val_a_d;
                    val_b_q     <= val_b_d;
                    icode_q     <= icode;
                    bad_icode_q <= (icode > 4'hB);
                    if (icode == 4'h0) halted_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign srcA      = src_a_q;
    assign srcB      = src_b_q;
    assign dstE      = dst_e_q;
    assign dstM      = dst_m_q;
    assign valA      = val_a_q;
    assign valB      = val_b_q;
    assign out_icode = icode_q;
    assign halted    = halted_q;
    assign bad_icode = bad_icode_q;

endmodule

// File: tb/tb_decode_regfile.sv
module tb_decode_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  icode, ifun, rA, rB;
    logic        cnd, stall;
    logic [3:0]  wb_dstE, wb_dstM;
    logic [63:0] wb_valE, wb_valM;
    logic        out_valid, halted, bad_icode;
    logic [3:0]  srcA, srcB, dstE, dstM, out_icode;
    logic [63:0] valA, valB;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_regfile dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .cnd(cnd), .stall(stall),
        .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
        .wb_valE(wb_valE), .wb_valM(wb_valM),
        .out_valid(out_valid), .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .dstM(dstM), .valA(valA), .valB(valB),
        .out_icode(out_icode), .halted(halted), .bad_icode(bad_icode)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic [3:0]  e_srca;
        logic [3:0]  e_srcb;
        logic [3:0]  e_dste;
        logic [3:0]  e_dstm;
        logic [63:0] e_vala;
        logic [63:0] e_valb;
        logic        e_bad;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        stall    = 1'b0;
        wb_dstE  = 4'hF;
        wb_dstM  = 4'hF;
        wb_valE  = '0;
        wb_valM  = '0;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb, input logic c);
        in_valid = 1'b1;
        icode    = ic;
        ifun     = 4'h0;
        rA       = ra;
        rB       = rb;
        cnd      = c;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " srcA"},      64'(srcA),      64'hF);
        check({tag, " srcB"},      64'(srcB),      64'hF);
        check({tag, " dstE"},      64'(dstE),      64'hF);
        check({tag, " dstM"},      64'(dstM),      64'hF);
        check({tag, " valA"},      valA,           64'd0);
        check({tag, " valB"},      valB,           64'd0);
        check({tag, " out_icode"}, 64'(out_icode), 64'h1);
        check({tag, " halted"},    64'(halted),    64'd0);
        check({tag, " bad_icode"}, 64'(bad_icode), 64'd0);
    endtask

    initial begin
        logic [63:0] exp_bypass;

        //            icode  rA     rB    cnd  srcA   srcB   dstE   dstM   valA        valB        bad
        vecs[0]  = '{4'h2, 4'h1, 4'h2, 1'b1, 4'h1, 4'hF, 4'h2, 4'hF, 64'h101, 64'h0,   1'b0};
        vecs[1]  = '{4'h2, 4'h1, 4'h2, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 64'h101, 64'h0,   1'b0};
        vecs[2]  = '{4'h3, 4'hF, 4'h6, 1'b0, 4'hF, 4'hF, 4'h6, 4'hF, 64'h0,   64'h0,   1'b0};
        vecs[3]  = '{4'h4, 4'h7, 4'h8, 1'b0, 4'h7, 4'h8, 4'hF, 4'hF, 64'h107, 64'h108, 1'b0};
        vecs[4]  = '{4'h5, 4'h9, 4'hA, 1'b0, 4'hF, 4'hA, 4'hF, 4'h9, 64'h0,   64'h10A, 1'b0};
        vecs[5]  = '{4'h6, 4'hB, 4'hC, 1'b0, 4'hB, 4'hC, 4'hC, 4'hF, 64'h10B, 64'h10C, 1'b0};
        vecs[6]  = '{4'h7, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0,   1'b0};
        vecs[7]  = '{4'h8, 4'h1, 4'h2, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0,   64'h104, 1'b0};
        vecs[8]  = '{4'h9, 4'h1, 4'h2, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h104, 64'h104, 1'b0};
        vecs[9]  = '{4'hA, 4'hD, 4'h2, 1'b0, 4'hD, 4'h4, 4'h4, 4'hF, 64'h10D, 64'h104, 1'b0};
        vecs[10] = '{4'hB, 4'hE, 4'h2, 1'b0, 4'h4, 4'h4, 4'h4, 4'hE, 64'h104, 64'h104, 1'b0};
        vecs[11] = '{4'hC, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0,   1'b1};
        vecs[12] = '{4'hF, 4'h3, 4'h4, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0,   1'b1};
        vecs[13] = '{4'h1, 4'h1, 4'h2, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0,   1'b0};
        vecs[14] = '{4'h6, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0,   1'b0};

        // Reset state, observed while rst is still high.
        rst = 1'b1;
        idle_inputs();
        drive(4'h1, 4'hF, 4'hF, 1'b0);
        in_valid = 1'b0;
        #2;
        check_reset_vals("reset");
        step();
        step();
        rst = 1'b0;

        // Single write, then rrmovq reading it back.
        wb_dstE = 4'h3; wb_valE = 64'h1234;
        step();
        wb_dstE = 4'hF;
        drive(4'h2, 4'h3, 4'h5, 1'b1);
        step();
        in_valid = 1'b0;
        check("rrmovq out_valid", 64'(out_valid), 64'd1);
        check("rrmovq valA",      valA,           64'h1234);
        check("rrmovq srcA",      64'(srcA),      64'h3);
        check("rrmovq dstE",      64'(dstE),      64'h5);
        check("rrmovq dstM",      64'(dstM),      64'hF);
        step();
        check("idle out_valid",   64'(out_valid), 64'd0);
        check("idle holds dstE",  64'(dstE),      64'h5);

        // Preload reg i = 0x100 + i.
        for (int i = 0; i < 15; i++) begin
            wb_dstE = 4'(i);
            wb_valE = 64'h100 + 64'(i);
            step();
        end
        wb_dstE = 4'hF;

        // Back-to-back table of captures.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].icode, vecs[i].ra, vecs[i].rb, vecs[i].cnd);
            step();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d out_icode", i), 64'(out_icode), 64'(vecs[i].icode));
            check($sformatf("vec%0d srcA", i),      64'(srcA),      64'(vecs[i].e_srca));
            check($sformatf("vec%0d srcB", i),      64'(srcB),      64'(vecs[i].e_srcb));
            check($sformatf("vec%0d dstE", i),      64'(dstE),      64'(vecs[i].e_dste));
            check($sformatf("vec%0d dstM", i),      64'(dstM),      64'(vecs[i].e_dstm));
            check($sformatf("vec%0d valA", i),      valA,           vecs[i].e_vala);
            check($sformatf("vec%0d valB", i),      valB,           vecs[i].e_valb);
            check($sformatf("vec%0d bad_icode", i), 64'(bad_icode), 64'(vecs[i].e_bad));
        end
        in_valid = 1'b0;
        step();

        // Shared writeback target: M wins.
        wb_dstE = 4'h4; wb_valE = 64'hAA;
        wb_dstM = 4'h4; wb_valM = 64'hBB;
        step();
        wb_dstE = 4'hF; wb_dstM = 4'hF;
        drive(4'hB, 4'h1, 4'hF, 1'b0);
        step();
        in_valid = 1'b0;
        check("wb tie valA", valA, 64'hBB);
        check("wb tie valB", valB, 64'hBB);

        // Capture during a same-edge writeback.
        wb_dstE = 4'h4; wb_valE = 64'h10;
        step();
        wb_dstE = 4'hF;
        wb_dstM = 4'h4; wb_valM = 64'h77;
        drive(4'hB, 4'h1, 4'hF, 1'b0);
        step();
`ifdef DECODE_WB_BYPASS_EN
        exp_bypass = 64'h77;
`else
        exp_bypass = 64'h10;
`endif
        check("same-edge popq valA", valA, exp_bypass);
        wb_dstM = 4'hF;
        step();
        in_valid = 1'b0;
        check("after wb popq valA", valA, 64'h77);

        // Stall for three cycles while writes keep landing.
        drive(4'h6, 4'h1, 4'h2, 1'b0);
        step();
        drive(4'h3, 4'hF, 4'h7, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_dstE = 4'(5 + i);
            wb_valE = 64'h5555 + 64'(i);
            step();
            check($sformatf("stall%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d out_icode", i), 64'(out_icode), 64'h6);
            check($sformatf("stall%0d dstE", i),      64'(dstE),      64'h2);
            check($sformatf("stall%0d valA", i),      valA,           64'h101);
        end
        stall   = 1'b0;
        wb_dstE = 4'hF;
        drive(4'h6, 4'h5, 4'h7, 1'b0);
        step();
        check("post-stall valA", valA, 64'h5555);
        check("post-stall valB", valB, 64'h5557);

        // Reset asserted mid-stall clears outputs without a clock edge.
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("mid-stall rst");
        step();
        rst   = 1'b0;
        stall = 1'b0;
        drive(4'h6, 4'h5, 4'h7, 1'b0);
        step();
        in_valid = 1'b0;
        check("regs cleared valA", valA, 64'h0);

        // Halt blocks later captures; writeback keeps going.
        wb_dstE = 4'h1; wb_valE = 64'h42;
        step();
        wb_dstE = 4'hF;
        drive(4'h0, 4'hF, 4'hF, 1'b0);
        step();
        check("halt halted",    64'(halted),    64'd1);
        check("halt out_valid", 64'(out_valid), 64'd1);
        check("halt out_icode", 64'(out_icode), 64'h0);
        drive(4'h6, 4'h1, 4'h2, 1'b0);
        wb_dstE = 4'h1; wb_valE = 64'h99;
        step();
        wb_dstE = 4'hF;
        check("halted out_valid", 64'(out_valid), 64'd0);
        check("halted out_icode", 64'(out_icode), 64'h0);
        check("halted srcA",      64'(srcA),      64'hF);
        check("halted sticky",    64'(halted),    64'd1);
        step();
        check("halted still idle", 64'(out_valid), 64'd0);

        rst = 1'b1;
        #1;
        check("rst clears halted", 64'(halted), 64'd0);
        step();
        rst = 1'b0;
        drive(4'h6, 4'h1, 4'h2, 1'b0);
        step();
        in_valid = 1'b0;
        check("post-halt out_valid", 64'(out_valid), 64'd1);
        check("post-halt valA",      valA,           64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
